// File: rtl/deskew_sequencer.sv
// -----------------------------------------------------------------------------
// deskew_sequencer
//
// Control block for the receive deskew datapath. Measures, in valid cycles, the
// relative arrival of each lane's start-of-lane (alignment marker) strobe,
// computes per-lane FIFO delays, issues a one-cycle load strobe to the deskew
// FIFO bank and then holds alignment status until a resync, disable or reset.
//
// Optional feature macro: DESKEW_RECHECK_EN
//   Defined   : LOCKED keeps measuring every AM round and compares the new
//               per-lane offsets with the stored ones; a mismatch or a round
//               timeout is handled exactly like an i_resync event.
//   Undefined : LOCKED ignores i_start_of_lane.
//
// Ports:
//   i_clock           clock
//   i_reset           synchronous active-low reset
//   i_enable          block enable, low forces IDLE
//   i_valid           datapath valid, gates all counting and sampling
//   i_start_of_lane   per-lane AM arrival strobe, lane k at bit N_LANES-1-k
//   i_resync          per-lane loss-of-AM-lock request, same ordering
//   o_lane_delay      per-lane FIFO delay, lane k at [(N_LANES-k)*NB_DELAY-1 -: NB_DELAY]
//   o_set_fifo_delay  one-cycle strobe, FIFOs load o_lane_delay
//   o_fifo_flush      one-cycle strobe, FIFOs clear pointers
//   o_deskew_done     high while aligned (LOCKED)
//   o_invalid_skew    one-cycle strobe, skew exceeded MAX_SKEW
// -----------------------------------------------------------------------------
module deskew_sequencer #(
  parameter int unsigned N_LANES    = 20,
  parameter int unsigned MAX_SKEW   = 16,
  parameter int unsigned FIFO_DEPTH = 20,
  parameter int unsigned NB_DELAY   = 5
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_enable,
  input  logic                         i_valid,
  input  logic [N_LANES-1:0]           i_start_of_lane,
  input  logic [N_LANES-1:0]           i_resync,
  output logic [N_LANES*NB_DELAY-1:0]  o_lane_delay,
  output logic                         o_set_fifo_delay,
  output logic                         o_fifo_flush,
  output logic                         o_deskew_done,
  output logic                         o_invalid_skew
);

  // Arrivals never exceed MAX_SKEW < FIFO_DEPTH, so a FIFO-address-wide counter suffices.
  localparam int unsigned       NB_CNT  = $clog2(FIFO_DEPTH);
  localparam logic [NB_CNT-1:0] MAX_CNT = NB_CNT'(MAX_SKEW);

  typedef enum logic [2:0] {
    StIdle,
    StWaitFirst,
    StCount,
    StApply,
    StLocked
  } state_t;

  state_t                       r_state;
  logic [N_LANES-1:0]           r_captured;
  logic [NB_CNT-1:0]            r_counter;
  logic [NB_CNT-1:0]            r_max;
  logic [NB_CNT-1:0]            r_arrival [N_LANES];
  logic [N_LANES*NB_DELAY-1:0]  r_lane_delay;
  logic                         r_set_fifo_delay;
  logic                         r_fifo_flush;
  logic                         r_deskew_done;
  logic                         r_invalid_skew;

  logic [N_LANES-1:0]           w_capture;
  logic [N_LANES-1:0]           w_flags_next;
  logic                         w_all;
  logic                         w_started;
  logic                         w_timeout;
  logic                         w_resync;
  logic [N_LANES*NB_DELAY-1:0]  w_apply_delay;

  // Capture/timeout decode shared by the measurement states. While waiting for
  // the first strobe the counter is zero, so first arrivals store 0 naturally.
  always_comb begin
    w_capture     = i_valid ? (i_start_of_lane & ~r_captured) : '0;
    w_flags_next  = r_captured | w_capture;
    w_all         = &w_flags_next;
    w_started     = |w_flags_next;
    // Counter would step past MAX_SKEW with lanes still missing.
    w_timeout     = i_valid && w_started && !w_all && (r_counter == MAX_CNT);
    w_resync      = |i_resync;
    w_apply_delay = '0;
    for (int b = 0; b < N_LANES; b++) begin
      w_apply_delay[b*NB_DELAY +: NB_DELAY] = NB_DELAY'(r_max - r_arrival[b]);
    end
  end

`ifdef DESKEW_RECHECK_EN
  logic [NB_CNT-1:0] w_max_next;
  logic [NB_CNT-1:0] w_arr_next [N_LANES];
  logic              w_mismatch;

  // Offsets of the round completing this cycle, compared against the held ones.
  always_comb begin
    w_max_next = (|w_capture) ? r_counter : r_max;
    w_mismatch = 1'b0;
    for (int b = 0; b < N_LANES; b++) begin
      w_arr_next[b] = w_capture[b] ? r_counter : r_arrival[b];
      if (NB_DELAY'(w_max_next - w_arr_next[b]) != r_lane_delay[b*NB_DELAY +: NB_DELAY]) begin
        w_mismatch = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state          <= StIdle;
      r_captured       <= '0;
      r_counter        <= '0;
      r_max            <= '0;
      for (int b = 0; b < N_LANES; b++) begin
        r_arrival[b] <= '0;
      end
      r_lane_delay     <= '0;
      r_set_fifo_delay <= 1'b0;
      r_fifo_flush     <= 1'b0;
      r_deskew_done    <= 1'b0;
      r_invalid_skew   <= 1'b0;
    end else begin
      r_set_fifo_delay <= 1'b0;
      r_fifo_flush     <= 1'b0;
      r_invalid_skew   <= 1'b0;
      if (!i_enable) begin
        r_state       <= StIdle;
        r_captured    <= '0;
        r_counter     <= '0;
        r_deskew_done <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            r_captured <= '0;
            r_counter  <= '0;
            r_state    <= StWaitFirst;
          end

          StWaitFirst, StCount: begin
            if (w_resync || w_timeout) begin
              // Resync wins over timeout, so invalid_skew only on a pure timeout.
              r_invalid_skew <= !w_resync;
              r_fifo_flush   <= !r_fifo_flush;
              r_captured     <= '0;
              r_counter      <= '0;
              r_state        <= StWaitFirst;
            end else begin
              r_captured <= w_flags_next;
              for (int b = 0; b < N_LANES; b++) begin
                if (w_capture[b]) r_arrival[b] <= r_counter;
              end
              // Counter is monotonic, so the latest capture is the maximum.
              if (|w_capture) r_max <= r_counter;
              if (i_valid && w_started) r_counter <= r_counter + 1'b1;
              if (w_all) begin
                r_state <= StApply;
              end else if (w_started) begin
                r_state <= StCount;
              end
            end
          end

          StApply: begin
            r_lane_delay     <= w_apply_delay;
            r_set_fifo_delay <= 1'b1;
            r_captured       <= '0;
            r_counter        <= '0;
            r_state          <= StLocked;
          end

          StLocked: begin
            if (w_resync) begin
              r_deskew_done <= 1'b0;
              r_fifo_flush  <= !r_fifo_flush;
              r_captured    <= '0;
              r_counter     <= '0;
              r_state       <= StWaitFirst;
            end
`ifdef DESKEW_RECHECK_EN
            else if (w_timeout || (w_all && w_mismatch)) begin
              r_deskew_done <= 1'b0;
              r_fifo_flush  <= !r_fifo_flush;
              r_captured    <= '0;
              r_counter     <= '0;
              r_state       <= StWaitFirst;
            end else if (w_all) begin
              // Matching round: start listening for the next one.
              r_deskew_done <= 1'b1;
              r_captured    <= '0;
              r_counter     <= '0;
            end else begin
              r_deskew_done <= 1'b1;
              r_captured    <= w_flags_next;
              for (int b = 0; b < N_LANES; b++) begin
                if (w_capture[b]) r_arrival[b] <= r_counter;
              end
              if (|w_capture) r_max <= r_counter;
              if (i_valid && w_started) r_counter <= r_counter + 1'b1;
            end
`else
            else begin
              r_deskew_done <= 1'b1;
            end
`endif
          end

          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign o_lane_delay     = r_lane_delay;
  assign o_set_fifo_delay = r_set_fifo_delay;
  assign o_fifo_flush     = r_fifo_flush;
  assign o_deskew_done    = r_deskew_done;
  assign o_invalid_skew   = r_invalid_skew;

endmodule

// File: tb/tb_deskew_sequencer.sv
// Directed bench for deskew_sequencer (default parameters).
module tb_deskew_sequencer;

  localparam int N  = 20;
  localparam int NB = 5;

  logic            i_clock = 1'b0;
  logic            i_reset;
  logic            i_enable;
  logic            i_valid;
  logic [N-1:0]    i_start_of_lane;
  logic [N-1:0]    i_resync;
  logic [N*NB-1:0] o_lane_delay;
  logic            o_set_fifo_delay;
  logic            o_fifo_flush;
  logic            o_deskew_done;
  logic            o_invalid_skew;

  int n_checks = 0;
  int n_errors = 0;

  deskew_sequencer dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_enable         (i_enable),
    .i_valid          (i_valid),
    .i_start_of_lane  (i_start_of_lane),
    .i_resync         (i_resync),
    .o_lane_delay     (o_lane_delay),
    .o_set_fifo_delay (o_set_fifo_delay),
    .o_fifo_flush     (o_fifo_flush),
    .o_deskew_done    (o_deskew_done),
    .o_invalid_skew   (o_invalid_skew)
  );

  always #5 i_clock = ~i_clock;

  function automatic logic [N-1:0] lane_bit(input int k);
    logic [N-1:0] v;
    v = '0;
    v[N-1-k] = 1'b1;
    return v;
  endfunction

  function automatic logic [NB-1:0] lane_dly(input int k);
    return o_lane_delay[(N-k)*NB-1 -: NB];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_delay"}, 32'(o_lane_delay != '0), 32'd0);
    check({tag, "_set"},   32'(o_set_fifo_delay), 32'd0);
    check({tag, "_flush"}, 32'(o_fifo_flush), 32'd0);
    check({tag, "_done"},  32'(o_deskew_done), 32'd0);
    check({tag, "_inv"},   32'(o_invalid_skew), 32'd0);
  endtask

  logic [N-1:0] grp;

  initial begin
    i_reset = 1'b0; i_enable = 1'b0; i_valid = 1'b0;
    i_start_of_lane = '0; i_resync = '0;
    tick(); tick();
    check_zero("rst");

    i_reset = 1'b1; i_enable = 1'b1;
    tick();  // IDLE -> WAIT_FIRST

    // Lanes 0..19 one valid cycle apart: counter passes 16 at lane 16.
    i_valid = 1'b1;
    for (int c = 0; c < N; c++) begin
      i_start_of_lane = lane_bit(c);
      tick();
      check($sformatf("to_inv_c%0d", c),   32'(o_invalid_skew), 32'(c == 16));
      check($sformatf("to_flush_c%0d", c), 32'(o_fifo_flush), 32'(c == 16));
      check($sformatf("to_set_c%0d", c),   32'(o_set_fifo_delay), 32'd0);
    end
    i_start_of_lane = '0; i_enable = 1'b0;
    tick();
    i_enable = 1'b1;
    tick();  // WAIT_FIRST

    // Lane k arrives at valid cycle k mod 4.
    for (int g = 0; g < 4; g++) begin
      grp = '0;
      for (int k = 0; k < N; k++) if (k % 4 == g) grp |= lane_bit(k);
      i_start_of_lane = grp;
      tick();
    end
    check("m4_set_early", 32'(o_set_fifo_delay), 32'd0);
    i_start_of_lane = '0;
    tick();
    check("m4_set", 32'(o_set_fifo_delay), 32'd1);
    check("m4_done_early", 32'(o_deskew_done), 32'd0);
    for (int k = 0; k < N; k++) check($sformatf("m4_dly%0d", k), 32'(lane_dly(k)), 32'(3 - k % 4));
    tick();
    check("m4_done", 32'(o_deskew_done), 32'd1);
    check("m4_set_once", 32'(o_set_fifo_delay), 32'd0);

    // Resync on lane 7 while locked, then all lanes aligned.
    i_resync = lane_bit(7);
    tick();
    check("rs_done", 32'(o_deskew_done), 32'd0);
    check("rs_flush", 32'(o_fifo_flush), 32'd1);
    i_resync = '0;
    i_start_of_lane = '1;
    tick();
    check("al_flush_once", 32'(o_fifo_flush), 32'd0);
    check("al_set_early", 32'(o_set_fifo_delay), 32'd0);
    i_start_of_lane = '0;
    tick();
    check("al_set", 32'(o_set_fifo_delay), 32'd1);
    check("al_dly0", 32'(lane_dly(0)), 32'd0);
    check("al_dly3", 32'(lane_dly(3)), 32'd0);
    check("al_dly_all", 32'(o_lane_delay), 32'd0);
    tick();
    check("al_done", 32'(o_deskew_done), 32'd1);

    // Valid gap: lanes 1..19 first, lane 0 one valid cycle later after 5 idle cycles.
    i_resync = lane_bit(0);
    tick();
    check("vg_flush", 32'(o_fifo_flush), 32'd1);
    i_resync = '0;
    i_start_of_lane = ~lane_bit(0);
    tick();
    for (int c = 0; c < 5; c++) begin
      i_valid = 1'b0;
      i_start_of_lane = (c == 0) ? (lane_bit(0) | lane_bit(1)) : '0;
      tick();
    end
    check("vg_no_set", 32'(o_set_fifo_delay), 32'd0);
    i_valid = 1'b1;
    i_start_of_lane = lane_bit(0) | lane_bit(1);
    tick();
    i_start_of_lane = '0;
    tick();
    check("vg_set", 32'(o_set_fifo_delay), 32'd1);
    check("vg_dly1", 32'(lane_dly(1)), 32'd1);
    check("vg_dly0", 32'(lane_dly(0)), 32'd0);
    check("vg_dly19", 32'(lane_dly(19)), 32'd1);
    tick();
    check("vg_done", 32'(o_deskew_done), 32'd1);

`ifdef DESKEW_RECHECK_EN
    // Matching round keeps lock; a shifted round drops it.
    i_start_of_lane = ~lane_bit(0);
    tick();
    i_start_of_lane = lane_bit(0);
    tick();
    check("rc_match_done", 32'(o_deskew_done), 32'd1);
    check("rc_match_flush", 32'(o_fifo_flush), 32'd0);
    i_start_of_lane = '1;
    tick();
    check("rc_shift_done", 32'(o_deskew_done), 32'd0);
    check("rc_shift_flush", 32'(o_fifo_flush), 32'd1);
    i_start_of_lane = '0;
    tick();
`else
    // Strobes while locked are ignored.
    i_start_of_lane = '1;
    tick();
    check("lk_ign_done", 32'(o_deskew_done), 32'd1);
    check("lk_ign_flush", 32'(o_fifo_flush), 32'd0);
    i_start_of_lane = '0;
    tick();
    check("lk_ign_set", 32'(o_set_fifo_delay), 32'd0);
    check("lk_ign_dly1", 32'(lane_dly(1)), 32'd1);
`endif

    // Disable: done drops, delays hold.
    i_enable = 1'b0;
    tick();
    check("en_done", 32'(o_deskew_done), 32'd0);
    check("en_dly1", 32'(lane_dly(1)), 32'd1);
    i_enable = 1'b1;
    tick();

    // Reset during COUNT clears everything.
    i_start_of_lane = lane_bit(0);
    tick();
    i_start_of_lane = '0;
    i_reset = 1'b0;
    tick();
    check_zero("rst2");
    i_reset = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
